line_capture: RTL
=================

# line_capture

Downstream stage of the EOC/EOS edge detectors in the linear-sensor readout path. It samples the external ADC word on every EOC edge pulse into a ping-pong pair of line banks and closes the line on the EOS edge pulse. It then streams the completed line out on a valid/ready pixel interface while the next line is captured. It replaces the LED-only pixel counter as the consumer of the edge pulses.

## Interface
- PIX_MAX, 1024: pixel slots per bank; pixel index width is $clog2(PIX_MAX)+1 (11 bits at default).
- DW, 12: ADC data width.
- FPGA_CLK  in  1  sole clock; all logic on the rising edge.
- FPGA_RST  in  1  reset, synchronous, active-high.
- EOC_EDGE  in  1  single-cycle pulse, one per pixel conversion end.
- EOS_EDGE  in  1  single-cycle pulse, end of scan (line).
- ADC_DATA  in  DW  pixel value, stable when EOC_EDGE is high.
- PIX_DATA  out  DW  streamed pixel value.
- PIX_INDEX  out  11  pixel index within line, 0-based.
- PIX_LAST  out  1  high with the final pixel of a line.
- PIX_VALID  out  1  output beat valid.
- PIX_READY  in  1  consumer accepts the beat when VALID&READY.
- LINE_COUNT  out  16  lines handed to readout, wraps at 65535->0.
- DROP_COUNT  out  16  lines discarded because readout was busy, saturates at 65535.
- OVERFLOW  out  1  sticky: more than PIX_MAX EOC edges in one line.

## Operation
- Capture side: write pointer `wr_idx` into bank `wr_bank`. On EOC_EDGE with `wr_idx` < PIX_MAX: write ADC_DATA at `wr_idx`, then `wr_idx`++. At `wr_idx` == PIX_MAX: discard the sample, set OVERFLOW, and leave `wr_idx` unchanged.
- On EOS_EDGE, with line length L = `wr_idx` (after any same-cycle write):
  - L == 0: no handoff; counters unchanged.
  - Readout IDLE: swap banks, load `rd_len` = L, LINE_COUNT++, start readout.
  - Readout busy: drop the line. Bank is not swapped, DROP_COUNT++ (saturating).
  - In all cases `wr_idx` is cleared to 0.
- When EOC_EDGE and EOS_EDGE are high in the same cycle, the sample belongs to the closing line: it is written first, then the line closes.
- Readout FSM:
  - IDLE -> FETCH on handoff.
  - FETCH: present `rd_idx` to the RAM (1-cycle read latency) -> LOAD.
  - LOAD: register the RAM output into PIX_DATA/PIX_INDEX/PIX_LAST; assert PIX_VALID -> HOLD.
  - HOLD: on VALID&READY, if PIX_LAST -> IDLE, else `rd_idx`++ -> FETCH.
- PIX_LAST = (`rd_idx` == `rd_len`-1).
- Output stability: while VALID is high and READY is low, PIX_DATA, PIX_INDEX and PIX_LAST hold steady. VALID is never withdrawn without acceptance.
- Banks are inferred simple dual-port RAM (2×PIX_MAX×DW). No reset on RAM contents.

## Timing
- Reset values: PIX_VALID=0, PIX_DATA=0, PIX_INDEX=0, PIX_LAST=0, LINE_COUNT=0, DROP_COUNT=0, OVERFLOW=0, `wr_idx`=0, `wr_bank`=0, FSM=IDLE.
- Reset mid-line or mid-readout: the line is abandoned. PIX_VALID is low the cycle after FPGA_RST is sampled high.
- EOS_EDGE sampled at edge t -> FSM in FETCH after t. PIX_VALID is first high after edge t+2.
- Maximum throughput is 1 pixel per 3 cycles with READY tied high. A 1024-pixel line drains in 3072 cycles, well inside the line period at DIV=8.
- Back-to-back EOC_EDGE pulses on consecutive cycles are all captured.

## Configuration
- `LINE_CAPTURE_TEST_PATTERN_EN` defined: the capture side writes {`wr_idx`} zero-extended/truncated to DW instead of ADC_DATA, giving a ramp 0,1,2,… per line. All other behaviour is identical.
- Undefined: ADC_DATA is stored; the port is still present in both builds.

## Test plan
- Reset, then 4 EOC_EDGE pulses with ADC_DATA=0x100..0x103, then EOS_EDGE, READY=1 -> 4 beats: data 0x100..0x103, index 0..3, PIX_LAST only on index 3; LINE_COUNT=1.
- Same line, READY low for 10 cycles on beat 2 -> beat 2 data/index stable for 10 cycles, VALID held high, no beat lost or duplicated.
- Line of 1030 EOC pulses then EOS -> 1024 beats, last index 1023; OVERFLOW=1 and stays 1 until reset.
- Second EOS arriving while the first line is still streaming (READY=0) -> DROP_COUNT=1, LINE_COUNT=1; the first line's data is uncorrupted when READY resumes.
- EOC_EDGE and EOS_EDGE high in the same cycle after 2 prior pulses -> line of 3 beats, last beat carries the coincident sample; an EOS with no EOC -> no beats, counters unchanged.
- FPGA_RST asserted mid-readout -> VALID low next cycle, counters 0. The next full line reads out from index 0. With the macro defined, data equals index.

Source files
------------

// File: rtl/line_capture.sv
// line_capture: ping-pong line capture of ADC words on EOC/EOS pulses, streamed out on a valid/ready pixel port.
// LINE_CAPTURE_TEST_PATTERN_EN stores a per-line index ramp instead of ADC_DATA.
module line_capture #(
  parameter int PIX_MAX = 1024,
  parameter int DW = 12,
  localparam int IW = $clog2(PIX_MAX) + 1,
  localparam int AW = IW - 1
) (
  input  logic          FPGA_CLK,
  input  logic          FPGA_RST,
  input  logic          EOC_EDGE,
  input  logic          EOS_EDGE,
  input  logic [DW-1:0] ADC_DATA,
  output logic [DW-1:0] PIX_DATA,
  output logic [IW-1:0] PIX_INDEX,
  output logic          PIX_LAST,
  output logic          PIX_VALID,
  input  logic          PIX_READY,
  output logic [15:0]   LINE_COUNT,
  output logic [15:0]   DROP_COUNT,
  output logic          OVERFLOW
);
  typedef enum logic [1:0] {IDLE, FETCH, LOAD, HOLD} state_t;
  state_t state;
  logic [DW-1:0] mem [0:1][0:PIX_MAX-1];
  logic [DW-1:0] wr_data, rd_q;
  logic [IW-1:0] wr_idx, rd_idx, rd_len, line_len;
  logic wr_bank, do_wr, close, handoff;
  always_comb begin
    do_wr = EOC_EDGE && (wr_idx < IW'(PIX_MAX));
    line_len = wr_idx + IW'(do_wr);
    close = EOS_EDGE && (line_len != '0);
    handoff = close && (state == IDLE);
  end
`ifdef LINE_CAPTURE_TEST_PATTERN_EN
  assign wr_data = DW'(wr_idx);
`else
  assign wr_data = ADC_DATA;
`endif
  // readout always uses the bank the capture side is not filling
  always_ff @(posedge FPGA_CLK) begin
    if (do_wr) mem[wr_bank][wr_idx[AW-1:0]] <= wr_data;
    rd_q <= mem[~wr_bank][rd_idx[AW-1:0]];
  end
  always_ff @(posedge FPGA_CLK) begin
    if (FPGA_RST) begin
      wr_idx <= '0;
      wr_bank <= 1'b0;
      LINE_COUNT <= '0;
      DROP_COUNT <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      if (EOC_EDGE && !do_wr) OVERFLOW <= 1'b1;
      wr_idx <= EOS_EDGE ? '0 : line_len;
      if (handoff) begin
        wr_bank <= ~wr_bank;
        LINE_COUNT <= LINE_COUNT + 16'd1;
      end
      if (close && !handoff && DROP_COUNT != 16'hffff) DROP_COUNT <= DROP_COUNT + 16'd1;
    end
  end
  always_ff @(posedge FPGA_CLK) begin
    if (FPGA_RST) begin
      state <= IDLE;
      rd_idx <= '0;
      rd_len <= '0;
      PIX_DATA <= '0;
      PIX_INDEX <= '0;
      PIX_LAST <= 1'b0;
      PIX_VALID <= 1'b0;
    end else begin
      case (state)
        IDLE: if (handoff) begin
          state <= FETCH;
          rd_idx <= '0;
          rd_len <= line_len;
        end
        FETCH: state <= LOAD;
        LOAD: begin
          state <= HOLD;
          PIX_DATA <= rd_q;
          PIX_INDEX <= rd_idx;
          PIX_LAST <= (rd_idx == rd_len - IW'(1));
          PIX_VALID <= 1'b1;
        end
        HOLD: if (PIX_READY) begin
          PIX_VALID <= 1'b0;
          state <= PIX_LAST ? IDLE : FETCH;
          rd_idx <= rd_idx + IW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
